speed_ramp_controller: RTL and testbench



---
 rtl/speed_ramp_controller.sv | 174 +++++++++++++++++
 tb/tb_speed_ramp_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/speed_ramp_controller.sv
// speed_ramp_controller
//   Game-state sequencer in front of the tick clock divider. Loads the start
//   speed when a game begins and raises it by STEP every POINTS_PER_STEP
//   points, up to MAX_SPEED. Holds the divider in reset while the game is
//   idle, paused or over.
//
// Optional feature macro: HIGH_SCORE_EN (adds the highScore output).
//
// Ports:
//   inClock      in   system clock
//   reset        in   synchronous active-high reset
//   start        in   start/restart request, acts on its rising edge
//   pause        in   level-sensitive pause request
//   crash        in   collision indication (level), acted on in RUN/PAUSED
//   scorePulse   in   point scored, rising edge counts one point
//   speed        out  [19:0] speed value for the divider
//   dividerReset out  hold the divider in reset
//   running      out  high only while the game is running
//   level        out  [7:0] current difficulty level
//   score        out  [15:0] current score
//   highScore    out  [15:0] best score seen since reset (HIGH_SCORE_EN only)
module speed_ramp_controller #(
    parameter int START_SPEED     = 100,
    parameter int MAX_SPEED       = 400,
    parameter int STEP            = 10,
    parameter int POINTS_PER_STEP = 5
) (
    input  logic        inClock,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        crash,
    input  logic        scorePulse,
    output logic [19:0] speed,
    output logic        dividerReset,
    output logic        running,
    output logic [7:0]  level,
    output logic [15:0] score
`ifdef HIGH_SCORE_EN
    ,
    output logic [15:0] highScore
`endif
);

    localparam logic [19:0] START_V    = 20'(START_SPEED);
    localparam logic [20:0] MAX_W      = 21'(MAX_SPEED);
    localparam logic [20:0] STEP_W     = 21'(STEP);
    localparam logic [15:0] PTS_LAST   = 16'(POINTS_PER_STEP - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } state_t;

    state_t      state, state_n;
    logic        start_q, score_q;
    logic [15:0] point_cnt, point_cnt_n;
    logic [19:0] speed_n;
    logic        divider_reset_n, running_n;
    logic [7:0]  level_n;
    logic [15:0] score_n;
    logic [20:0] speed_sum;
    logic        start_edge, score_edge;

    assign start_edge = start & ~start_q;
    assign score_edge = scorePulse & ~score_q;
    // Sum carried at 21 bits so an overflow past bit 19 still clamps.
    assign speed_sum  = {1'b0, speed} + STEP_W;

    always_comb begin
        state_n         = state;
        speed_n         = speed;
        divider_reset_n = 1'b1;
        running_n       = 1'b0;
        level_n         = level;
        score_n         = score;
        point_cnt_n     = point_cnt;

        unique case (state)
            IDLE: begin
                speed_n = START_V;
                if (start_edge) begin
                    state_n         = RUN;
                    divider_reset_n = 1'b0;
                    running_n       = 1'b1;
                    level_n         = '0;
                    score_n         = '0;
                    point_cnt_n     = '0;
                end
            end
            RUN: begin
                if (crash) begin
                    state_n = OVER;
                end else if (pause) begin
                    state_n = PAUSED;
                end else begin
                    divider_reset_n = 1'b0;
                    running_n       = 1'b1;
                    if (score_edge) begin
                        if (score != '1)
                            score_n = score + 16'd1;
                        if (point_cnt == PTS_LAST) begin
                            point_cnt_n = '0;
                            if (level != '1)
                                level_n = level + 8'd1;
                            speed_n = (speed_sum > MAX_W) ? MAX_W[19:0] : speed_sum[19:0];
                        end else begin
                            point_cnt_n = point_cnt + 16'd1;
                        end
                    end
                end
            end
            PAUSED: begin
                if (crash) begin
                    state_n = OVER;
                end else if (!pause) begin
                    state_n         = RUN;
                    divider_reset_n = 1'b0;
                    running_n       = 1'b1;
                end
            end
            OVER: begin
                if (start_edge) begin
                    state_n         = RUN;
                    divider_reset_n = 1'b0;
                    running_n       = 1'b1;
                    speed_n         = START_V;
                    level_n         = '0;
                    score_n         = '0;
                    point_cnt_n     = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge inClock) begin
        if (reset) begin
            state        <= IDLE;
            speed        <= START_V;
            dividerReset <= 1'b1;
            running      <= 1'b0;
            level        <= '0;
            score        <= '0;
            point_cnt    <= '0;
            start_q      <= 1'b0;
            score_q      <= 1'b0;
        end else begin
            state        <= state_n;
            speed        <= speed_n;
            dividerReset <= divider_reset_n;
            running      <= running_n;
            level        <= level_n;
            score        <= score_n;
            point_cnt    <= point_cnt_n;
            start_q      <= start;
            score_q      <= scorePulse;
        end
    end

`ifdef HIGH_SCORE_EN
    // Score is frozen on the cycle that enters OVER, so the current score
    // is the final one for the game.
    always_ff @(posedge inClock) begin
        if (reset)
            highScore <= '0;
        else if (state_n == OVER && state != OVER && score > highScore)
            highScore <= score;
    end
`endif

endmodule

// File: tb/tb_speed_ramp_controller.sv
module tb_speed_ramp_controller;

    localparam int START = 100;
    localparam int MAXS  = 130;
    localparam int STEPV = 10;
    localparam int PPS   = 5;

    logic        clk = 1'b0;
    logic        rst, st, pa, cr, sp;
    logic [19:0] speed;
    logic        dividerReset, running;
    logic [7:0]  level;
    logic [15:0] score;
`ifdef HIGH_SCORE_EN
    logic [15:0] highScore;
`endif

    speed_ramp_controller #(
        .START_SPEED(START),
        .MAX_SPEED(MAXS),
        .STEP(STEPV),
        .POINTS_PER_STEP(PPS)
    ) dut (
        .inClock(clk),
        .reset(rst),
        .start(st),
        .pause(pa),
        .crash(cr),
        .scorePulse(sp),
        .speed(speed),
        .dividerReset(dividerReset),
        .running(running),
        .level(level),
        .score(score)
`ifdef HIGH_SCORE_EN
        ,
        .highScore(highScore)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] speed;
        logic        divr;
        logic        run;
        logic [7:0]  level;
        logic [15:0] score;
        logic [15:0] hs;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: game phase plus an unbounded count of points scored.
    // Level and speed are derived arithmetically from the point count.
    localparam int P_IDLE = 0, P_RUN = 1, P_PAUSED = 2, P_OVER = 3;
    int phase = P_IDLE;
    int points = 0;
    int hs = 0;
    bit prev_st = 0, prev_sp = 0;

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step();
        bit se, pe;
        exp_t e;
        int lv;
        se = st & ~prev_st;
        pe = sp & ~prev_sp;
        if (rst) begin
            phase = P_IDLE; points = 0; hs = 0;
            prev_st = 0; prev_sp = 0;
        end else begin
            prev_st = st; prev_sp = sp;
            case (phase)
                P_IDLE:   if (se) begin phase = P_RUN; points = 0; end
                P_RUN: begin
                    if (cr) begin
                        phase = P_OVER;
                        if (min_i(points, 65535) > hs) hs = min_i(points, 65535);
                    end else if (pa) phase = P_PAUSED;
                    else if (pe) points++;
                end
                P_PAUSED: begin
                    if (cr) begin
                        phase = P_OVER;
                        if (min_i(points, 65535) > hs) hs = min_i(points, 65535);
                    end else if (!pa) phase = P_RUN;
                end
                default:  if (se) begin phase = P_RUN; points = 0; end
            endcase
        end
        lv      = points / PPS;
        e.run   = (phase == P_RUN);
        e.divr  = (phase != P_RUN);
        e.score = 16'(min_i(points, 65535));
        e.level = 8'(min_i(lv, 255));
        e.speed = (phase == P_IDLE) ? 20'(START) : 20'(min_i(START + lv * STEPV, MAXS));
`ifdef HIGH_SCORE_EN
        e.hs    = 16'(hs);
`else
        e.hs    = '0;
`endif
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs away from the active edge, record expectation.
    task automatic cyc(input bit r, input bit s, input bit p, input bit c, input bit q);
        @(negedge clk);
        rst = r; st = s; pa = p; cr = c; sp = q;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, pa, 0, 0);
    endtask

    task automatic score_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 0, 0, 1);
            for (int j = 0; j < 3; j++) cyc(0, 0, 0, 0, 0);
        end
    endtask

    // Monitor: outputs are presented every cycle, compare just after the edge.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.speed = speed; a.divr = dividerReset; a.run = running;
                a.level = level; a.score = score;
`ifdef HIGH_SCORE_EN
                a.hs = highScore;
`else
                a.hs = '0;
`endif
                total++;
                if (a !== e) begin
                    bad++;
                    if (bad <= 20)
                        $display("FAIL outputs t=%0t: got spd=%0d dr=%0b run=%0b lvl=%0d sc=%0d hs=%0d expected spd=%0d dr=%0b run=%0b lvl=%0d sc=%0d hs=%0d",
                                 $time, a.speed, a.divr, a.run, a.level, a.score, a.hs,
                                 e.speed, e.divr, e.run, e.level, e.score, e.hs);
                end
            end
        end
    end

    initial begin
        rst = 1; st = 0; pa = 0; cr = 0; sp = 0;
        // Reset and idle.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        idle(10);
        // Start, first level-up after 5 points.
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        score_pulses(5);
        // Continue to 25 points: speed clamps at the ceiling.
        score_pulses(20);
        // Crash with a simultaneous score edge: edge dropped.
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0);
        idle(3);
        cyc(0, 1, 0, 0, 0);
        idle(3);
        // Pause held with score pulses underneath.
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, (i % 6) == 2);
        cyc(0, 0, 0, 0, 0);
        idle(2);
        // Held scorePulse counts once.
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);
        idle(3);
        // Start ignored while running, crash from PAUSED.
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        idle(2);
        // High score sequence: 7 then crash, 3 then crash, reset.
        cyc(0, 1, 0, 0, 0);
        score_pulses(7);
        cyc(0, 0, 0, 1, 0);
        idle(2);
        cyc(0, 1, 0, 0, 0);
        score_pulses(3);
        cyc(0, 0, 0, 1, 0);
        idle(2);
        cyc(1, 0, 0, 0, 0);
        idle(3);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, s, p, c, q;
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 24) == 0);
            p = ($urandom_range(0, 7) == 0) ? ~pa : pa;
            c = ($urandom_range(0, 79) == 0);
            q = $urandom_range(0, 1);
            cyc(r, s, p, c, q);
        end
        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
